// File: rtl/mano_control_sequencer.sv
// mano_control_sequencer
//   Timing and control unit for the basic-computer datapath. It runs the
//   sequence counter T0..T6 and latches the opcode decode (D0..D7) and the
//   indirect bit I at the T2 edge. Each cycle it drives the common-bus select
//   and the register, memory and ALU strobes. These cover fetch, indirect,
//   memory-reference and register-reference instructions.
//
//   Ports
//     clk, rst          rising-edge clock, synchronous active-high reset
//     ir[15:0]          IR contents: [15]=I, [14:12]=opcode, [11:0]=addr/B-field
//     ac_zero, ac_sign  AC==0, AC[15]
//     e_flag, dr_zero   E register, DR==0
//     mem_ready         memory access completes this cycle (wait-state build)
//     start             leave the HALT state
//     t[2:0]            current timing state
//     bus_sel[2:0]      0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
//     *_ld/_inc/_clr    datapath register strobes; e_cmp complements E
//     mem_rd, mem_wr    read/write of M[AR]
//     alu_op[2:0]       0 NOP, 1 AND, 2 ADD, 3 XFER(DR), 4 CMA, 5 CIR, 6 CIL
//     halted            HLT executed; sequencer idle
//
//   Build option
//     MANO_MEM_WAIT_EN  when defined, a memory cycle with mem_ready=0 stalls.
//                       t holds and mem_rd/mem_wr/bus_sel stay up. Every other
//                       strobe is suppressed until the mem_ready=1 cycle. When
//                       undefined, mem_ready is ignored.

module mano_control_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        ac_zero,
  input  logic        ac_sign,
  input  logic        e_flag,
  input  logic        dr_zero,
  input  logic        mem_ready,
  input  logic        start,
  output logic [2:0]  t,
  output logic [2:0]  bus_sel,
  output logic        ar_ld,
  output logic        ar_inc,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        dr_ld,
  output logic        dr_inc,
  output logic        ac_ld,
  output logic        ac_clr,
  output logic        ac_inc,
  output logic        ir_ld,
  output logic        e_clr,
  output logic        e_cmp,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [2:0]  alu_op,
  output logic        halted
);

  localparam logic [2:0] BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
                         BUS_AC = 3'd4, BUS_IR = 3'd5, BUS_MEM = 3'd7;
  localparam logic [2:0] ALU_NOP = 3'd0, ALU_AND = 3'd1, ALU_ADD = 3'd2, ALU_XFER = 3'd3,
                         ALU_CMA = 3'd4, ALU_CIR = 3'd5, ALU_CIL = 3'd6;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} t_state_e;

  t_state_e   t_reg;
  logic [7:0] d_reg;
  logic       i_reg;
  logic       halted_reg;

  logic [7:0]  d_dec;
  logic [11:0] rr_sel;
  genvar gi;

  // One-hot opcode decode, captured into d_reg at the T2 edge.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_d_dec
      assign d_dec[gi] = (ir[14:12] == 3'(gi));
    end
  endgenerate

  // Register-reference priority: only the highest set B-bit is kept.
  assign rr_sel[11] = ir[11];
  generate
    for (gi = 0; gi < 11; gi++) begin : g_rr_pri
      assign rr_sel[gi] = ir[gi] & ~(|ir[11:gi+1]);
    end
  endgenerate

  logic       rr_exec;
  logic       hlt_exec;
  logic       last_state;
  logic [2:0] raw_bus, raw_alu;
  logic raw_ar_ld, raw_ar_inc, raw_pc_ld, raw_pc_inc, raw_dr_ld, raw_dr_inc;
  logic raw_ac_ld, raw_ac_clr, raw_ac_inc, raw_ir_ld, raw_e_clr, raw_e_cmp;
  logic raw_mem_rd, raw_mem_wr;

  assign rr_exec  = (t_reg == T3) && d_reg[7] && !i_reg;
  assign hlt_exec = rr_exec && rr_sel[0];

  always_comb begin
    raw_bus = BUS_NONE;  raw_alu = ALU_NOP;
    raw_ar_ld = 1'b0;  raw_ar_inc = 1'b0; raw_pc_ld = 1'b0;  raw_pc_inc = 1'b0;
    raw_dr_ld = 1'b0;  raw_dr_inc = 1'b0; raw_ac_ld = 1'b0;  raw_ac_clr = 1'b0;
    raw_ac_inc = 1'b0; raw_ir_ld = 1'b0;  raw_e_clr = 1'b0;  raw_e_cmp = 1'b0;
    raw_mem_rd = 1'b0; raw_mem_wr = 1'b0;
    case (t_reg)
      T0: begin raw_bus = BUS_PC; raw_ar_ld = 1'b1; end
      T1: begin raw_bus = BUS_MEM; raw_mem_rd = 1'b1; raw_ir_ld = 1'b1; raw_pc_inc = 1'b1; end
      T2: begin raw_bus = BUS_IR; raw_ar_ld = 1'b1; end
      T3: begin
        if (!d_reg[7] && i_reg) begin
          // Indirect: AR <- M[AR]
          raw_bus = BUS_MEM; raw_mem_rd = 1'b1; raw_ar_ld = 1'b1;
        end else if (rr_exec) begin
          if (rr_sel[11]) raw_ac_clr = 1'b1;
          if (rr_sel[10]) raw_e_clr  = 1'b1;
          if (rr_sel[9])  begin raw_alu = ALU_CMA; raw_ac_ld = 1'b1; end
          if (rr_sel[8])  raw_e_cmp  = 1'b1;
          if (rr_sel[7])  begin raw_alu = ALU_CIR; raw_ac_ld = 1'b1; end
          if (rr_sel[6])  begin raw_alu = ALU_CIL; raw_ac_ld = 1'b1; end
          if (rr_sel[5])  raw_ac_inc = 1'b1;
          if (rr_sel[4])  raw_pc_inc = !ac_sign;
          if (rr_sel[3])  raw_pc_inc = ac_sign;
          if (rr_sel[2])  raw_pc_inc = ac_zero;
          if (rr_sel[1])  raw_pc_inc = !e_flag;
        end
      end
      T4: begin
        if (d_reg[0] || d_reg[1] || d_reg[2] || d_reg[6]) begin
          raw_bus = BUS_MEM; raw_mem_rd = 1'b1; raw_dr_ld = 1'b1;
        end
        if (d_reg[3]) begin raw_bus = BUS_AC; raw_mem_wr = 1'b1; end
        if (d_reg[4]) begin raw_bus = BUS_AR; raw_pc_ld = 1'b1; end
        if (d_reg[5]) begin raw_bus = BUS_PC; raw_mem_wr = 1'b1; raw_ar_inc = 1'b1; end
      end
      T5: begin
        if (d_reg[0]) begin raw_alu = ALU_AND;  raw_ac_ld = 1'b1; end
        if (d_reg[1]) begin raw_alu = ALU_ADD;  raw_ac_ld = 1'b1; end
        if (d_reg[2]) begin raw_alu = ALU_XFER; raw_ac_ld = 1'b1; end
        if (d_reg[5]) begin raw_bus = BUS_AR; raw_pc_ld = 1'b1; end
        if (d_reg[6]) raw_dr_inc = 1'b1;
      end
      T6: begin
        if (d_reg[6]) begin raw_bus = BUS_DR; raw_mem_wr = 1'b1; raw_pc_inc = dr_zero; end
      end
      default: ;
    endcase
  end

  // Final cycle of each instruction class; T6 always wraps so t can never pass 6.
  always_comb begin
    last_state = 1'b0;
    case (t_reg)
      T3:      last_state = d_reg[7];
      T4:      last_state = d_reg[3] | d_reg[4];
      T5:      last_state = d_reg[0] | d_reg[1] | d_reg[2] | d_reg[5];
      T6:      last_state = 1'b1;
      default: last_state = 1'b0;
    endcase
  end

  logic stall;
`ifdef MANO_MEM_WAIT_EN
  assign stall = (raw_mem_rd | raw_mem_wr) & ~mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      t_reg      <= T0;
      d_reg      <= 8'h00;
      i_reg      <= 1'b0;
      halted_reg <= 1'b0;
    end else if (halted_reg) begin
      t_reg <= T0;
      if (start) halted_reg <= 1'b0;
    end else if (!stall) begin
      if (t_reg == T2) begin
        d_reg <= d_dec;
        i_reg <= ir[15];
      end
      if (hlt_exec) halted_reg <= 1'b1;
      t_reg <= last_state ? T0 : t_state_e'(t_reg + 3'd1);
    end
  end

  // Reset or halt silences everything. A stall keeps only the memory handshake visible.
  logic kill, hold_kill;
  assign kill      = rst | halted_reg;
  assign hold_kill = kill | stall;

  assign t       = t_reg;
  assign halted  = halted_reg;
  assign bus_sel = kill ? BUS_NONE : raw_bus;
  assign mem_rd  = raw_mem_rd & ~kill;
  assign mem_wr  = raw_mem_wr & ~kill;
  assign alu_op  = hold_kill ? ALU_NOP : raw_alu;
  assign ar_ld   = raw_ar_ld  & ~hold_kill;
  assign ar_inc  = raw_ar_inc & ~hold_kill;
  assign pc_ld   = raw_pc_ld  & ~hold_kill;
  assign pc_inc  = raw_pc_inc & ~hold_kill;
  assign dr_ld   = raw_dr_ld  & ~hold_kill;
  assign dr_inc  = raw_dr_inc & ~hold_kill;
  assign ac_ld   = raw_ac_ld  & ~hold_kill;
  assign ac_clr  = raw_ac_clr & ~hold_kill;
  assign ac_inc  = raw_ac_inc & ~hold_kill;
  assign ir_ld   = raw_ir_ld  & ~hold_kill;
  assign e_clr   = raw_e_clr  & ~hold_kill;
  assign e_cmp   = raw_e_cmp  & ~hold_kill;

endmodule
